// File: rtl/jtframe_db15_rx_if.sv
// Bundle between the DB15 receiver and the adaptor / joystick mux: serial pins
// toward the adaptor, decoded button words and frame strobe toward the mux.
interface jtframe_db15_rx_if #(
  parameter int NBITS = 16
);
  logic             JOY_DATA;
  logic             JOY_CLK;
  logic             JOY_LOAD;
  logic [NBITS-1:0] joystick1;
  logic [NBITS-1:0] joystick2;
  logic             frame_done;
  logic [1:0]       state_dbg;

  // Handshake: there is no back-pressure. frame_done is a one-cycle strobe that
  // acts as 'valid' for joystick1/2; the words are held stable between strobes,
  // so a consumer may sample them on any cycle (ready is implicitly always 1).
  modport master (
    input  JOY_DATA,
    output JOY_CLK, JOY_LOAD, joystick1, joystick2, frame_done, state_dbg
  );
  modport slave (
    output JOY_DATA,
    input  JOY_CLK, JOY_LOAD, joystick1, joystick2, frame_done, state_dbg
  );
endinterface

// File: rtl/jtframe_db15_rx.sv
// DB15 adaptor serial receiver: periodically parallel-loads the adaptor chain,
// clocks out 2*NBITS bits and publishes two active-high button words.
module jtframe_db15_rx #(
  parameter int CLKDIV = 8,
  parameter int PERIOD = 48000,
  parameter int NBITS  = 16
) (
  input  logic               clk,
  input  logic               rst,
  jtframe_db15_rx_if.master  joy
);
  localparam int FB = 2 * NBITS;
  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = $clog2(FB) + 1;
  localparam logic [TW-1:0] TMAX = TW'(PERIOD - 1);
  localparam logic [DW-1:0] DMAX = DW'(CLKDIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(FB - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [DW-1:0]    div_q, div_d;
  logic             phase_q, phase_d;   // 0: JOY_CLK low phase, 1: high phase
  logic [BW-1:0]    bit_q, bit_d;
  logic [FB-1:0]    shift_q, shift_d;
  logic [1:0]       sync_q, sync_d;
  logic             joy_clk_q, joy_clk_d;
  logic             joy_load_q, joy_load_d;
  logic [NBITS-1:0] j1_q, j1_d;
  logic [NBITS-1:0] j2_q, j2_d;
  logic             done_q, done_d;
  logic             expired;

  assign expired = (timer_q == TMAX);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    j1_d    = j1_q;
    j2_d    = j2_q;
    sync_d  = {sync_q[0], joy.JOY_DATA};

    case (state_q)
      IDLE: begin
        if (expired) begin
          state_d = LOAD;
          div_d   = '0;
        end
      end
      LOAD: begin
        if (div_q == DMAX) begin
          state_d = SHIFT;
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (div_q != DMAX) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!phase_q) begin
            // Last low-phase cycle: the adaptor has had the whole phase to settle.
            shift_d[bit_q[BW-2:0]] = sync_q[1];
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == BMAX) state_d = DONE;
            else               bit_d   = bit_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Words are published together with the frame_done strobe.
    if (state_d == DONE) begin
      j1_d = ~shift_q[NBITS-1:0];
      j2_d = ~shift_q[FB-1:NBITS];
    end

    if (state_d == LOAD && state_q != LOAD) timer_d = '0;
    else if (!expired)                      timer_d = timer_q + 1'b1;

    joy_clk_d  = !(state_d == SHIFT && !phase_d);
    joy_load_d = (state_d != LOAD);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= TMAX;
      div_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      shift_q    <= '0;
      sync_q     <= 2'b11;
      joy_clk_q  <= 1'b1;
      joy_load_q <= 1'b1;
      j1_q       <= '0;
      j2_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      sync_q     <= sync_d;
      joy_clk_q  <= joy_clk_d;
      joy_load_q <= joy_load_d;
      j1_q       <= j1_d;
      j2_q       <= j2_d;
      done_q     <= done_d;
    end
  end

  assign joy.JOY_CLK    = joy_clk_q;
  assign joy.JOY_LOAD   = joy_load_q;
  assign joy.joystick1  = j1_q;
  assign joy.joystick2  = j2_q;
  assign joy.frame_done = done_q;
  assign joy.state_dbg  = state_q;

endmodule
